memport_sched: RTL and testbench

Per-port request scheduler in front of one `memblk` read/write port pair. It shares the port between `NREQ` requesters using independent round-robin arbitration for reads and writes, and honours `memblk` back-pressure (`stall`). It tracks each in-flight read in a tag pipeline that moves in lock-step with the `memblk` pipeline, so every returning `rddata` is steered to the requester that issued it. One instance sits per used port index (0..35) between the tile's load/store agents and `memblk`.

---
 rtl/memport_sched.sv | 205 ++++++++++++++++++++
 tb/tb_memport_sched.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memport_sched.sv
// memport_sched: shares one memblk read/write port between NREQ requesters.
// Reads and writes have independent round-robin arbiters. A LAT-deep tag
// pipeline, frozen together with memblk on stall, steers each returning
// rddata to the requester that issued it.
// Optional build macro: MEMPORT_SCHED_WRPRIO_EN -- reads and writes share one
// issue slot and any eligible write blocks all reads for that cycle.
module memport_sched #(
  parameter int NREQ   = 4,
  parameter int LAT    = 48,
  parameter int MAXOUT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_we,
  input  logic [NREQ*39-1:0]   req_addr,
  input  logic [NREQ*533-1:0]  req_wdata,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [532:0]         rsp_data,
  output logic [39:0]          rsp_phy,
  output logic                 orphan,
  input  logic                 stall,
  output logic                 mem_rden,
  output logic                 mem_wren,
  output logic [38:0]          mem_rdaddr,
  output logic [38:0]          mem_wraddr,
  output logic [532:0]         mem_wrdata,
  input  logic [532:0]         mem_rddata,
  input  logic [39:0]          mem_rdphy,
  input  logic                 mem_rdval
);
  localparam int DATA_W = 533;
  localparam int ADDR_W = 39;
  localparam int PW     = (NREQ > 2) ? $clog2(NREQ) : 1;
  localparam logic [3:0] MAXOUT_C = 4'(MAXOUT);

  // Round-robin search: first eligible index at or after ptr, with wrap.
  // Returns {found, index}.
  function automatic logic [PW:0] rr_pick(input logic [NREQ-1:0] elig,
                                          input logic [PW-1:0]   ptr);
    logic [PW:0] res;
    int          idx;
    res = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!res[PW] && elig[idx]) res = {1'b1, PW'(idx)};
    end
    return res;
  endfunction

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] win);
    return (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
  endfunction

  // Credit counter update, saturating at MAXOUT and never wrapping below 0.
  function automatic logic [3:0] outst_upd(input logic [3:0] cnt,
                                           input logic inc, input logic dec);
    logic [3:0] nxt;
    nxt = cnt;
    if (inc && !dec && cnt < MAXOUT_C)       nxt = cnt + 4'd1;
    else if (dec && !inc && cnt != 4'd0)     nxt = cnt - 4'd1;
    return nxt;
  endfunction

  logic [ADDR_W-1:0] w_addr  [NREQ];
  logic [DATA_W-1:0] w_wdata [NREQ];
  logic [3:0]        r_outst [NREQ];
  logic [NREQ-1:0]   w_rd_elig, w_wr_elig, w_rd_gnt, w_wr_gnt;
  logic [PW:0]       w_rd_pick, w_wr_pick;
  logic              w_rd_go, w_wr_go;
  logic [PW-1:0]     r_rptr, r_wptr;

  logic              r_rden_p0, r_wren_p0;
  logic [ADDR_W-1:0] r_rdaddr_p0, r_wraddr_p0;
  logic [DATA_W-1:0] r_wrdata_p0;
  logic [PW-1:0]     r_rdid_p0;

  logic [LAT-1:0]    r_tag_vld_p1;
  logic [PW-1:0]     r_tag_id_p1 [LAT];
  logic              w_rsp_fire, w_tail_vld;
  logic [PW-1:0]     w_tail_id;
  logic              r_orphan;

  // Unpack the per-requester address and write-data buses.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      w_addr[i]  = req_addr[i*ADDR_W +: ADDR_W];
      w_wdata[i] = req_wdata[i*DATA_W +: DATA_W];
    end
  end

  // Eligibility and round-robin winners; nothing is granted in reset or stall.
  always_comb begin
    w_rd_elig = '0;
    w_wr_elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_rd_elig[i] = req_valid[i] & ~req_we[i] & (r_outst[i] < MAXOUT_C) & ~stall & ~rst;
      w_wr_elig[i] = req_valid[i] &  req_we[i] & ~stall & ~rst;
    end
    w_rd_pick = rr_pick(w_rd_elig, r_rptr);
    w_wr_pick = rr_pick(w_wr_elig, r_wptr);
    w_wr_go   = w_wr_pick[PW];
`ifdef MEMPORT_SCHED_WRPRIO_EN
    w_rd_go   = w_rd_pick[PW] & ~w_wr_go;
`else
    w_rd_go   = w_rd_pick[PW];
`endif
    w_rd_gnt = '0;
    w_wr_gnt = '0;
    if (w_rd_go) w_rd_gnt[w_rd_pick[PW-1:0]] = 1'b1;
    if (w_wr_go) w_wr_gnt[w_wr_pick[PW-1:0]] = 1'b1;
  end

  assign grant = w_rd_gnt | w_wr_gnt;

  // Arbiter pointers advance past the winner only when something is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rptr <= '0;
      r_wptr <= '0;
    end else begin
      if (w_rd_go) r_rptr <= ptr_next(w_rd_pick[PW-1:0]);
      if (w_wr_go) r_wptr <= ptr_next(w_wr_pick[PW-1:0]);
    end
  end

  // ---- stage p0: issue register, held while memblk stalls ----
  // Issue register; address/data are kept from the last winner when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rden_p0   <= 1'b0;
      r_wren_p0   <= 1'b0;
      r_rdaddr_p0 <= '0;
      r_wraddr_p0 <= '0;
      r_wrdata_p0 <= '0;
      r_rdid_p0   <= '0;
    end else if (!stall) begin
      r_rden_p0 <= w_rd_go;
      r_wren_p0 <= w_wr_go;
      if (w_rd_go) begin
        r_rdaddr_p0 <= w_addr[w_rd_pick[PW-1:0]];
        r_rdid_p0   <= w_rd_pick[PW-1:0];
      end
      if (w_wr_go) begin
        r_wraddr_p0 <= w_addr[w_wr_pick[PW-1:0]];
        r_wrdata_p0 <= w_wdata[w_wr_pick[PW-1:0]];
      end
    end
  end

  assign mem_rden   = r_rden_p0;
  assign mem_wren   = r_wren_p0;
  assign mem_rdaddr = r_rdaddr_p0;
  assign mem_wraddr = r_wraddr_p0;
  assign mem_wrdata = r_wrdata_p0;

  // ---- stage p1: tag pipeline, lock-step with the memblk read pipeline ----
  // Tag valid bits; reset drops every in-flight read.
  always_ff @(posedge clk) begin
    if (rst)         r_tag_vld_p1 <= '0;
    else if (!stall) r_tag_vld_p1 <= {r_tag_vld_p1[LAT-2:0], r_rden_p0};
  end

  // Tag ids ride beside the valid bits; meaningless where valid is low.
  always_ff @(posedge clk) begin
    if (!stall) begin
      r_tag_id_p1[0] <= r_rdid_p0;
      for (int k = 1; k < LAT; k++) r_tag_id_p1[k] <= r_tag_id_p1[k-1];
    end
  end

  assign w_rsp_fire = mem_rdval & ~stall & ~rst;
  assign w_tail_vld = r_tag_vld_p1[LAT-1];
  assign w_tail_id  = r_tag_id_p1[LAT-1];
  assign rsp_data   = mem_rddata;
  assign rsp_phy    = mem_rdphy;

  // Steer a returning read to the requester recorded in the tail tag.
  always_comb begin
    rsp_valid = '0;
    if (w_rsp_fire && w_tail_vld) rsp_valid[w_tail_id] = 1'b1;
  end

  // Sticky flag for a memblk response that no live tag accounts for.
  always_ff @(posedge clk) begin
    if (rst)                            r_orphan <= 1'b0;
    else if (w_rsp_fire && !w_tail_vld) r_orphan <= 1'b1;
  end

  assign orphan = r_orphan;

  // Per-requester read credits: +1 on read grant, -1 on delivered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) r_outst[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        assert (!(rsp_valid[i] && !w_rd_gnt[i] && r_outst[i] == 4'd0));
        r_outst[i] <= outst_upd(r_outst[i], w_rd_gnt[i], rsp_valid[i]);
      end
    end
  end

endmodule

// File: tb/tb_memport_sched.sv
// tb_memport_sched: directed bench for memport_sched with a memblk stand-in
// and a transaction-level model (round-robin search, credit counts and a list
// of in-flight reads counting down unstalled edges) checked every cycle.
module tb_memport_sched;
  localparam int NREQ   = 4;
  localparam int LAT    = 48;
  localparam int MAXOUT = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid, req_we;
  logic [NREQ*39-1:0]  req_addr;
  logic [NREQ*533-1:0] req_wdata;
  logic [NREQ-1:0]     grant, rsp_valid;
  logic [532:0]        rsp_data;
  logic [39:0]         rsp_phy;
  logic                orphan, stall;
  logic                mem_rden, mem_wren;
  logic [38:0]         mem_rdaddr, mem_wraddr;
  logic [532:0]        mem_wrdata, mem_rddata;
  logic [39:0]         mem_rdphy;
  logic                mem_rdval;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  memport_sched #(.NREQ(NREQ), .LAT(LAT), .MAXOUT(MAXOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .grant(grant),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_phy(rsp_phy),
    .orphan(orphan), .stall(stall), .mem_rden(mem_rden), .mem_wren(mem_wren),
    .mem_rdaddr(mem_rdaddr), .mem_wraddr(mem_wraddr), .mem_wrdata(mem_wrdata),
    .mem_rddata(mem_rddata), .mem_rdphy(mem_rdphy), .mem_rdval(mem_rdval)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [532:0] mkdata(input logic [38:0] a);
    return {455'd0, ~a, a};
  endfunction

  // memblk stand-in: not reset, frozen by stall, LAT unstalled edges deep.
  logic [LAT-1:0] mb_v = '0;
  logic [38:0]    mb_a [LAT];
  always @(posedge clk) begin
    if (!stall) begin
      mb_v    <= {mb_v[LAT-2:0], mem_rden};
      mb_a[0] <= mem_rdaddr;
      for (int k = 1; k < LAT; k++) mb_a[k] <= mb_a[k-1];
    end
  end
  assign mem_rdval  = mb_v[LAT-1];
  assign mem_rddata = mkdata(mb_a[LAT-1]);
  assign mem_rdphy  = {1'b1, mb_a[LAT-1]};

  task automatic chk(input string nm, input logic [532:0] act, input logic [532:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_rptr = 0, m_wptr = 0;
  int          m_out [NREQ] = '{default: 0};
  logic        m_orphan = 1'b0;
  logic        m_rden = 1'b0, m_wren = 1'b0;
  logic [38:0] m_rdaddr = '0, m_wraddr = '0;
  logic [532:0] m_wrdata = '0;
  int          fl_id [$];
  int          fl_rem [$];
  logic [38:0] fl_addr [$];

  task automatic model_step();
    logic [NREQ-1:0] el_r, el_w, e_gnt, e_rsp;
    int rw, ww, due, idx;
    bit rf, wf, rgo, fire;
    el_r = '0; el_w = '0; rw = 0; ww = 0; rf = 0; wf = 0;
    for (int i = 0; i < NREQ; i++) begin
      el_r[i] = !rst && !stall && req_valid[i] && !req_we[i] && (m_out[i] < MAXOUT);
      el_w[i] = !rst && !stall && req_valid[i] &&  req_we[i];
    end
    for (int k = 0; k < NREQ; k++) begin
      idx = (m_rptr + k) % NREQ;
      if (!rf && el_r[idx]) begin rf = 1; rw = idx; end
      idx = (m_wptr + k) % NREQ;
      if (!wf && el_w[idx]) begin wf = 1; ww = idx; end
    end
    rgo = rf;
`ifdef MEMPORT_SCHED_WRPRIO_EN
    if (wf) rgo = 0;
`endif
    e_gnt = '0;
    if (rgo) e_gnt[rw] = 1'b1;
    if (wf)  e_gnt[ww] = 1'b1;
    due = -1;
    for (int j = 0; j < fl_rem.size(); j++) if (fl_rem[j] == 0) due = j;
    fire  = !rst && !stall && mem_rdval;
    e_rsp = '0;
    if (fire && due >= 0) e_rsp[fl_id[due]] = 1'b1;

    chk("grant", grant, e_gnt);
    chk("rsp_valid", rsp_valid, e_rsp);
    chk("mem_rden", mem_rden, m_rden);
    chk("mem_wren", mem_wren, m_wren);
    chk("orphan", orphan, m_orphan);
    if (m_rden) chk("mem_rdaddr", mem_rdaddr, m_rdaddr);
    if (m_wren) begin
      chk("mem_wraddr", mem_wraddr, m_wraddr);
      chk("mem_wrdata", mem_wrdata, m_wrdata);
    end
    if (!rst && !stall && due >= 0) chk("rdval_due", mem_rdval, 1);
    if (fire && due >= 0) begin
      chk("rsp_data", rsp_data, mkdata(fl_addr[due]));
      chk("rsp_phy", rsp_phy, {1'b1, fl_addr[due]});
    end

    if (rst) begin
      m_rptr = 0; m_wptr = 0; m_orphan = 0; m_rden = 0; m_wren = 0;
      m_rdaddr = '0; m_wraddr = '0; m_wrdata = '0;
      for (int i = 0; i < NREQ; i++) m_out[i] = 0;
      fl_id.delete(); fl_rem.delete(); fl_addr.delete();
    end else if (!stall) begin
      if (due >= 0) begin
        m_out[fl_id[due]]--;
        fl_id.delete(due); fl_rem.delete(due); fl_addr.delete(due);
      end else if (mem_rdval) begin
        m_orphan = 1'b1;
      end
      for (int j = 0; j < fl_rem.size(); j++) fl_rem[j] = fl_rem[j] - 1;
      m_rden = rgo;
      m_wren = wf;
      if (rgo) begin
        m_out[rw]++;
        m_rdaddr = req_addr[rw*39 +: 39];
        fl_id.push_back(rw); fl_rem.push_back(LAT); fl_addr.push_back(m_rdaddr);
        m_rptr = (rw + 1) % NREQ;
      end
      if (wf) begin
        m_wraddr = req_addr[ww*39 +: 39];
        m_wrdata = req_wdata[ww*533 +: 533];
        m_wptr   = (ww + 1) % NREQ;
      end
    end
  endtask

  initial begin : compare
    @(posedge clk);
    forever begin
      @(negedge clk);
      model_step();
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int i, input logic [38:0] a);
    req_valid[i] = 1'b1;
    req_we[i]    = 1'b0;
    req_addr[i*39 +: 39] = a;
  endtask

  task automatic set_wr(input int i, input logic [38:0] a, input logic [532:0] d);
    req_valid[i] = 1'b1;
    req_we[i]    = 1'b1;
    req_addr[i*39 +: 39]   = a;
    req_wdata[i*533 +: 533] = d;
  endtask

  task automatic wait_rsp(input string nm, input int maxc, output int c);
    int n;
    bit found;
    n = 0; found = 0;
    while (!found && n < maxc) begin
      @(negedge clk);
      if (rsp_valid != '0) found = 1;
      else n++;
    end
    if (!found) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: no rsp_valid within %0d cycles", nm, maxc);
    end
    c = cyc;
  endtask

  int g, g0, c, ngr, nrsp;
  logic [NREQ-1:0] tmp;

  initial begin : stim
    rst = 1'b1; stall = 1'b0;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_mem_rden", mem_rden, 0);
    chk("rst_mem_wren", mem_wren, 0);
    chk("rst_orphan", orphan, 0);

    // Round-robin fairness with all four reading.
    tick();
    for (int i = 0; i < NREQ; i++) set_rd(i, 39'h1000 + 39'(i));
    g0 = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) g0 = cyc;
      chk("rr_order", grant, 4'b0001 << (k % 4));
    end
    wait_rsp("rr_first", 100, c);
    chk("rr_latency", c - g0, 49);
    chk("rr_rsp0", rsp_valid, 4'b0001);
    chk("rr_data0", rsp_data, mkdata(39'h1000));
    @(negedge clk);
    chk("rr_rsp1", rsp_valid, 4'b0010);
    tick();
    req_valid = '0;
    repeat (LAT + 15) tick();

    // Stall freeze: grant at g, stall over g+10..g+14, response at g+54.
    set_rd(0, 39'h2000);
    @(negedge clk);
    g = cyc;
    chk("st_grant", grant, 4'b0001);
    tick();
    req_valid[0] = 1'b0;
    while (cyc < g + 10) tick();
    stall = 1'b1;
    set_rd(1, 39'h2001);
    repeat (5) begin
      @(negedge clk);
      chk("st_nogrant", grant, 0);
      chk("st_rdaddr", mem_rdaddr, 39'h2000);
      tick();
    end
    stall = 1'b0;
    @(negedge clk);
    chk("st_release_grant", grant, 4'b0010);
    tick();
    req_valid[1] = 1'b0;
    wait_rsp("st_rsp", 100, c);
    chk("st_latency", c - g, 54);
    chk("st_rsp_id", rsp_valid, 4'b0001);
    repeat (LAT + 15) tick();

    // Credit limit on requester 2, requester 3 flows meanwhile.
    set_rd(2, 39'h3002);
    @(negedge clk);
    g = cyc;
    chk("cr_first", grant, 4'b0100);
    repeat (8) tick();
    set_rd(3, 39'h3003);
    @(negedge clk);
    chk("cr_ninth_skipped", grant, 4'b1000);
    while (cyc < g + 16) tick();
    @(negedge clk);
    chk("cr_both_full", grant, 0);
    while (cyc < g + 49) tick();
    @(negedge clk);
    chk("cr_return", rsp_valid, 4'b0100);
    chk("cr_still_full", grant, 0);
    tick();
    @(negedge clk);
    chk("cr_reenabled", grant, 4'b0100);
    tick();
    req_valid = '0;
    repeat (LAT + 25) tick();

    // Simultaneous write (req 0) and read (req 1).
    set_wr(0, 39'h4000, 533'h5A5A_1234_ABCD);
    set_rd(1, 39'h4001);
    @(negedge clk);
`ifdef MEMPORT_SCHED_WRPRIO_EN
    chk("rw_write_first", grant, 4'b0001);
    tick();
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("rw_read_next", grant, 4'b0010);
    chk("rw_wren", mem_wren, 1);
    chk("rw_rden_off", mem_rden, 0);
    tick();
    req_valid[1] = 1'b0;
    @(negedge clk);
    chk("rw_rden", mem_rden, 1);
    chk("rw_wren_off", mem_wren, 0);
`else
    chk("rw_both", grant, 4'b0011);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("rw_rden", mem_rden, 1);
    chk("rw_wren", mem_wren, 1);
    chk("rw_wraddr", mem_wraddr, 39'h4000);
    chk("rw_wrdata", mem_wrdata, 533'h5A5A_1234_ABCD);
`endif
    req_we = '0;
    repeat (LAT + 15) tick();

    // Reset with three reads in flight.
    set_rd(0, 39'h5000); set_rd(1, 39'h5001); set_rd(2, 39'h5002);
    ngr = 0;
    for (int j = 0; j < 10 && req_valid != '0; j++) begin
      @(negedge clk);
      tmp = grant;
      ngr += $countones(tmp);
      tick();
      req_valid = req_valid & ~tmp;
    end
    chk("rf_grants", ngr, 3);
    req_valid = '0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nrsp = 0;
    repeat (60) begin
      @(negedge clk);
      if (rsp_valid != '0) nrsp++;
      tick();
    end
    chk("rf_no_delivery", nrsp, 0);
    chk("rf_orphan", orphan, 1);
    set_rd(0, 39'h5100);
    ngr = 0;
    repeat (10) begin
      @(negedge clk);
      ngr += $countones(grant);
      tick();
    end
    chk("rf_credits_cleared", ngr, 8);
    req_valid = '0;
    repeat (LAT + 25) tick();

    // Pointer wrap: 3 then 0, pointer then sits at 1.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_rd(3, 39'h6003);
    @(negedge clk);
    chk("wrap_grant3", grant, 4'b1000);
    tick();
    req_valid[3] = 1'b0;
    set_rd(0, 39'h6000);
    @(negedge clk);
    chk("wrap_grant0", grant, 4'b0001);
    tick();
    for (int i = 0; i < NREQ; i++) set_rd(i, 39'h6100 + 39'(i));
    @(negedge clk);
    chk("wrap_ptr_at_1", grant, 4'b0010);
    tick();
    req_valid = '0;
    repeat (LAT + 15) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
